// File: rtl/latency_meter.sv
// rtl/latency_meter.sv - GMII frame latency meter: marker/stamp capture, CRC-32 check, latency statistics
`timescale 1ns/1ps
module latency_meter #(
  parameter logic [31:0] MAGIC     = 32'hdeadbeef,
  parameter logic [11:0] MAX_BYTES = 12'd1526,
  parameter logic [11:0] MIN_BYTES = 12'd72
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  input  logic [31:0] timer,
  input  logic        stats_clr,
  output logic        latency_valid,
  output logic [31:0] latency,
  output logic [31:0] lat_min,
  output logic [31:0] lat_max,
  output logic [47:0] lat_sum,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  typedef enum logic [2:0] {IDLE, PRE, BODY, DROP, DONE} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hd5;

  state_t      state_q, state_d;
  logic [11:0] idx_q, idx_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] marker_q, marker_d;
  logic [31:0] stamp_q, stamp_d;
  logic [31:0] delta_q, delta_d;
  logic        first_q;
  logic        accept;
  logic        count_bad;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    marker_d  = marker_q;
    stamp_d   = stamp_q;
    delta_d   = delta_q;
    accept    = 1'b0;
    count_bad = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // A frame already in flight when reset releases cannot be trusted.
        if (rx_dv && rx_data == PRE_BYTE && !first_q) begin
          state_d  = PRE;
          idx_d    = 12'd1;
          crc_d    = CRC_INIT;
          marker_d = 32'h0;
        end else if (rx_dv && state_q == IDLE) begin
          state_d = DROP;
        end
      end
      PRE: begin
        if (!rx_dv) begin
          count_bad = 1'b1;
          state_d   = IDLE;
        end else if ((idx_q == 12'd7) ? (rx_data == SFD_BYTE) : (rx_data == PRE_BYTE)) begin
          idx_d = idx_q + 12'd1;
          if (idx_q == 12'd7) state_d = BODY;
        end else begin
          state_d = DROP;
        end
      end
      BODY: begin
        if (!rx_dv) begin
          accept    = (idx_q >= MIN_BYTES) && (idx_q <= MAX_BYTES) &&
                      (marker_q == MAGIC) && (crc_q == CRC_RESIDUE);
          count_bad = !accept;
          state_d   = DONE;
        end else if (idx_q == MAX_BYTES) begin
          state_d = DROP;
        end else begin
          idx_d = idx_q + 12'd1;
          crc_d = crc32_byte(crc_q, rx_data);
          if (idx_q >= 12'h032 && idx_q <= 12'h035) marker_d = {marker_q[23:0], rx_data};
          if (idx_q >= 12'h036 && idx_q <= 12'h038) stamp_d = {stamp_q[23:0], rx_data};
          if (idx_q == 12'h039) delta_d = timer - {stamp_q[23:0], rx_data};
        end
      end
      DROP: begin
        if (!rx_dv) begin
          count_bad = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= 12'd0;
      crc_q         <= CRC_INIT;
      marker_q      <= 32'h0;
      stamp_q       <= 32'h0;
      delta_q       <= 32'h0;
      first_q       <= 1'b1;
      latency_valid <= 1'b0;
      latency       <= 32'h0;
      lat_min       <= 32'hffffffff;
      lat_max       <= 32'h0;
      lat_sum       <= 48'h0;
      good_cnt      <= 16'h0;
      bad_cnt       <= 16'h0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      marker_q      <= marker_d;
      stamp_q       <= stamp_d;
      delta_q       <= delta_d;
      first_q       <= 1'b0;
      latency_valid <= accept;
      if (accept) latency <= delta_q;
      // Clear takes priority over a coinciding frame outcome.
      if (stats_clr) begin
        lat_min  <= 32'hffffffff;
        lat_max  <= 32'h0;
        lat_sum  <= 48'h0;
        good_cnt <= 16'h0;
        bad_cnt  <= 16'h0;
      end else if (accept) begin
        if (delta_q < lat_min) lat_min <= delta_q;
        if (delta_q > lat_max) lat_max <= delta_q;
        lat_sum <= lat_sum + {16'h0, delta_q};
        if (good_cnt != 16'hffff) good_cnt <= good_cnt + 16'd1;
      end else if (count_bad && bad_cnt != 16'hffff) begin
        bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
endmodule
